// File: rtl/cordic_vec_arbiter.sv
// Two-requester round-robin front end for a fixed-latency CORDIC vectoring datapath,
// with credit-protected per-requester result FIFOs. Optional stats: CORDIC_ARB_STATS_EN.
module cordic_vec_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 16,
   parameter int LAT        = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_x,
   input  logic [DW-1:0] req0_y,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_x,
   input  logic [DW-1:0] req1_y,
   output logic          cordic_in_valid,
   output logic [DW-1:0] cordic_x,
   output logic [DW-1:0] cordic_y,
   input  logic [DW-1:0] cordic_mag,
   input  logic [AW-1:0] cordic_angle,
   output logic          res0_valid,
   input  logic          res0_ready,
   output logic [DW-1:0] res0_mag,
   output logic [AW-1:0] res0_angle,
   output logic          res1_valid,
   input  logic          res1_ready,
   output logic [DW-1:0] res1_mag,
   output logic [AW-1:0] res1_angle,
`ifdef CORDIC_ARB_STATS_EN
   output logic [31:0]   stat_issue0,
   output logic [31:0]   stat_issue1,
   output logic [31:0]   stat_stall,
`endif
   output logic          busy
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = DW + AW;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [1:0]          req_valid, res_ready, elig, grant, push, pop, empty;
   logic [1:0][DW-1:0]  req_x, req_y;
   logic [1:0][CW-1:0]  cnt_q, cnt_d, occ_q, occ_d;
   logic [1:0][PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [1:0][EW-1:0]  head;
   logic [EW-1:0]       mem_q [2][FIFO_DEPTH];
   logic                last_grant_q, last_grant_d;
   logic                in_valid_q, in_valid_d;
   logic [DW-1:0]       x_q, x_d, y_q, y_d;
   logic [LAT:0]        tvld_q, tvld_d, tid_q, tid_d;

   assign req_valid = {req1_valid, req0_valid};
   assign res_ready = {res1_ready, res0_ready};
   assign req_x     = {req1_x, req0_x};
   assign req_y     = {req1_y, req0_y};

   // Credits count in-flight tags plus FIFO occupancy, so a granted issue always has a slot.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         empty[i] = (occ_q[i] == '0);
         pop[i]   = !empty[i] && res_ready[i];
         elig[i]  = req_valid[i] && (cnt_q[i] < DEPTH_C);
      end
      if (elig == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else               grant = elig;
   end

   // Tag index LAT lines up with the datapath output of the issue made LAT cycles earlier.
   assign push = {tvld_q[LAT] & tid_q[LAT], tvld_q[LAT] & ~tid_q[LAT]};

   always_comb begin
      last_grant_d = last_grant_q;
      in_valid_d   = |grant;
      x_d          = x_q;
      y_d          = y_q;
      if (|grant) begin
         last_grant_d = grant[1];
         x_d          = req_x[grant[1]];
         y_d          = req_y[grant[1]];
      end
      tvld_d = {tvld_q[LAT-1:0], |grant};
      tid_d  = {tid_q[LAT-1:0], grant[1]};
      for (int i = 0; i < 2; i++) begin
         cnt_d[i]  = cnt_q[i] + CW'(grant[i]) - CW'(pop[i]);
         occ_d[i]  = occ_q[i] + CW'(push[i]) - CW'(pop[i]);
         wptr_d[i] = wptr_q[i] + PW'(push[i]);
         rptr_d[i] = rptr_q[i] + PW'(pop[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         in_valid_q   <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         tvld_q       <= '0;
         tid_q        <= '0;
         cnt_q        <= '0;
         occ_q        <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         in_valid_q   <= in_valid_d;
         x_q          <= x_d;
         y_q          <= y_d;
         tvld_q       <= tvld_d;
         tid_q        <= tid_d;
         cnt_q        <= cnt_d;
         occ_q        <= occ_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (push[i]) mem_q[i][wptr_q[i]] <= {cordic_mag, cordic_angle};
   end

   always_comb begin
      for (int i = 0; i < 2; i++) head[i] = mem_q[i][rptr_q[i]];
   end

   generate
      for (genvar g = 0; g < 2; g++) begin : g_chk
         a_no_overflow: assert property (@(posedge clk) disable iff (rst)
            !(push[g] && occ_q[g] == DEPTH_C && !pop[g]));
      end
   endgenerate

   assign req0_ready      = grant[0];
   assign req1_ready      = grant[1];
   assign cordic_in_valid = in_valid_q;
   assign cordic_x        = x_q;
   assign cordic_y        = y_q;
   assign res0_valid      = !empty[0];
   assign res1_valid      = !empty[1];
   assign {res0_mag, res0_angle} = head[0];
   assign {res1_mag, res1_angle} = head[1];
   assign busy = (|tvld_q) || !(&empty);

`ifdef CORDIC_ARB_STATS_EN
   logic [31:0] issue0_q, issue0_d, issue1_q, issue1_d, stall_q, stall_d;
   logic        stall;

   always_comb begin
      stall    = (req_valid[0] && cnt_q[0] == DEPTH_C) || (req_valid[1] && cnt_q[1] == DEPTH_C);
      issue0_d = issue0_q + 32'(grant[0]);
      issue1_d = issue1_q + 32'(grant[1]);
      stall_d  = stall_q + 32'(stall);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue0_q <= '0;
         issue1_q <= '0;
         stall_q  <= '0;
      end else begin
         issue0_q <= issue0_d;
         issue1_q <= issue1_d;
         stall_q  <= stall_d;
      end
   end

   assign stat_issue0 = issue0_q;
   assign stat_issue1 = issue1_q;
   assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// Bench for cordic_vec_arbiter: delay-line datapath (mag=x, angle=y low bits) and result scoreboard.
module tb_cordic_vec_arbiter;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int LAT = 16;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0, rst = 1'b1;
   logic req0_valid = 0, req1_valid = 0, res0_ready = 0, res1_ready = 0;
   logic [DW-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
   logic req0_ready, req1_ready, cordic_in_valid, res0_valid, res1_valid, busy;
   logic [DW-1:0] cordic_x, cordic_y, cordic_mag, res0_mag, res1_mag;
   logic [AW-1:0] cordic_angle, res0_angle, res1_angle;
`ifdef CORDIC_ARB_STATS_EN
   logic [31:0] stat_issue0, stat_issue1, stat_stall;
`endif

   int errors = 0, checks = 0, pops0 = 0, pops1 = 0;
   logic [DW+AW-1:0] exp0 [$];
   logic [DW+AW-1:0] exp1 [$];
   logic [DW-1:0] dl_x [LAT];
   logic [DW-1:0] dl_y [LAT];

   always #5 clk = ~clk;

   cordic_vec_arbiter #(.DW(DW), .AW(AW), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
      .cordic_in_valid(cordic_in_valid), .cordic_x(cordic_x), .cordic_y(cordic_y),
      .cordic_mag(cordic_mag), .cordic_angle(cordic_angle),
      .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_mag(res0_mag), .res0_angle(res0_angle),
      .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_mag(res1_mag), .res1_angle(res1_angle),
`ifdef CORDIC_ARB_STATS_EN
      .stat_issue0(stat_issue0), .stat_issue1(stat_issue1), .stat_stall(stat_stall),
`endif
      .busy(busy));

   // Datapath model: operand registered at issue edge, visible LAT cycles after cordic_in_valid.
   always @(posedge clk) begin
      dl_x[0] <= cordic_x;
      dl_y[0] <= cordic_y;
      for (int i = 1; i < LAT; i++) begin
         dl_x[i] <= dl_x[i-1];
         dl_y[i] <= dl_y[i-1];
      end
   end
   assign cordic_mag   = dl_x[LAT-1];
   assign cordic_angle = dl_y[LAT-1][AW-1:0];

   // Scoreboard: push on request handshake, pop and compare on result handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (req0_valid && req0_ready) exp0.push_back({req0_x, req0_y[AW-1:0]});
         if (req1_valid && req1_ready) exp1.push_back({req1_x, req1_y[AW-1:0]});
         if (res0_valid && res0_ready) begin
            logic [DW+AW-1:0] e;
            checks++; pops0++;
            if (exp0.size() == 0) begin
               errors++; $display("FAIL res0_unexpected got=%h expected none", {res0_mag, res0_angle});
            end else begin
               e = exp0.pop_front();
               if ({res0_mag, res0_angle} !== e) begin
                  errors++; $display("FAIL res0_data got=%h exp=%h", {res0_mag, res0_angle}, e);
               end
            end
         end
         if (res1_valid && res1_ready) begin
            logic [DW+AW-1:0] e;
            checks++; pops1++;
            if (exp1.size() == 0) begin
               errors++; $display("FAIL res1_unexpected got=%h expected none", {res1_mag, res1_angle});
            end else begin
               e = exp1.pop_front();
               if ({res1_mag, res1_angle} !== e) begin
                  errors++; $display("FAIL res1_data got=%h exp=%h", {res1_mag, res1_angle}, e);
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; req0_valid = 0; req1_valid = 0; res0_ready = 0; res1_ready = 0;
      exp0.delete(); exp1.delete();
      repeat (3) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk); n++;
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL drain_timeout busy=%b exp=0", busy); end
      checks++;
      if (exp0.size() + exp1.size() != 0) begin
         errors++; $display("FAIL drain_leftover got=%0d exp=0", exp0.size() + exp1.size());
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 6;
      if (cordic_in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid got=%b exp=0", cordic_in_valid); end
      if (cordic_x !== '0) begin errors++; $display("FAIL rst_x got=%h exp=0", cordic_x); end
      if (cordic_y !== '0) begin errors++; $display("FAIL rst_y got=%h exp=0", cordic_y); end
      if (res0_valid !== 1'b0) begin errors++; $display("FAIL rst_res0_valid got=%b exp=0", res0_valid); end
      if (res1_valid !== 1'b0) begin errors++; $display("FAIL rst_res1_valid got=%b exp=0", res1_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      @(posedge clk); #1 rst = 0;
   endtask

   task automatic test_single();
      int r1 = 0;
      @(posedge clk); #1;
      res0_ready = 1; res1_ready = 1;
      req0_valid = 1; req0_x = 32'h400; req0_y = 32'h300;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
      @(posedge clk); #1 req0_valid = 0;
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks += 3;
            if (cordic_in_valid !== 1'b1) begin errors++; $display("FAIL single_issue got=%b exp=1", cordic_in_valid); end
            if (cordic_x !== 32'h400) begin errors++; $display("FAIL single_cx got=%h exp=400", cordic_x); end
            if (cordic_y !== 32'h300) begin errors++; $display("FAIL single_cy got=%h exp=300", cordic_y); end
         end
         checks++;
         if (res0_valid !== (k == LAT + 2)) begin
            errors++; $display("FAIL single_latency k=%0d got=%b exp=%b", k, res0_valid, (k == LAT + 2));
         end
         if (res1_valid) r1++;
      end
      checks++;
      if (r1 != 0) begin errors++; $display("FAIL single_res1 got=%0d exp=0", r1); end
      wait_idle();
   endtask

   task automatic test_contention();
      int p0, p1;
      logic [1:0] eg;
      do_reset();
      res0_ready = 1; res1_ready = 1; p0 = pops0; p1 = pops1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         req0_valid = 1; req0_x = 32'h1000 + k; req0_y = 32'h20 + k;
         req1_valid = 1; req1_x = 32'h2000 + k; req1_y = 32'h40 + k;
         @(negedge clk);
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if ({req1_ready, req0_ready} !== eg) begin
            errors++; $display("FAIL contention_grant k=%0d got=%b exp=%b", k, {req1_ready, req0_ready}, eg);
         end
      end
      @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
      wait_idle();
      checks += 2;
      if (pops0 - p0 != 4) begin errors++; $display("FAIL contention_cnt0 got=%0d exp=4", pops0 - p0); end
      if (pops1 - p1 != 4) begin errors++; $display("FAIL contention_cnt1 got=%0d exp=4", pops1 - p1); end
   endtask

   task automatic test_credit_stall();
      int g = 0;
      do_reset();
      res0_ready = 0; res1_ready = 1;
      for (int k = 0; k < LAT + 16; k++) begin
         @(posedge clk); #1;
         req0_valid = 1; req0_x = 32'h3000 + k; req0_y = 32'h60 + k;
         @(negedge clk);
         if (k < 12) begin
            checks++;
            if (req0_ready !== (k < FIFO_DEPTH)) begin
               errors++; $display("FAIL credit_ready k=%0d got=%b exp=%b", k, req0_ready, (k < FIFO_DEPTH));
            end
         end
         if (req0_ready) g++;
      end
      checks++;
      if (g != FIFO_DEPTH) begin errors++; $display("FAIL credit_grants got=%0d exp=%0d", g, FIFO_DEPTH); end
      @(posedge clk); #1 res0_ready = 1;
      @(negedge clk);
      @(posedge clk); #1 res0_ready = 0;
      g = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (req0_ready) g++;
      end
      checks++;
      if (g != 1) begin errors++; $display("FAIL credit_regrant got=%0d exp=1", g); end
      @(posedge clk); #1 req0_valid = 0; res0_ready = 1;
      wait_idle();
   endtask

   task automatic test_share();
      do_reset();
      res0_ready = 0; res1_ready = 1;
      for (int k = 0; k < FIFO_DEPTH + 4; k++) begin
         @(posedge clk); #1;
         req0_valid = 1; req0_x = 32'h4000 + k; req0_y = 32'h80 + k;
         req1_valid = (k >= FIFO_DEPTH); req1_x = 32'h4800 + k; req1_y = 32'h90 + k;
         @(negedge clk);
         if (k >= FIFO_DEPTH) begin
            checks++;
            if ({req1_ready, req0_ready} !== 2'b10) begin
               errors++; $display("FAIL share_grant k=%0d got=%b exp=10", k, {req1_ready, req0_ready});
            end
         end
      end
      @(posedge clk); #1 req0_valid = 0; req1_valid = 0; res0_ready = 1;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int viol = 0;
      do_reset();
      res0_ready = 1; res1_ready = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         req0_valid = 1; req0_x = 32'h5000 + k; req0_y = 32'ha0 + k;
      end
      @(posedge clk); #1 req0_valid = 0;
      repeat (4) @(posedge clk);
      #1 rst = 1;
      exp0.delete(); exp1.delete();
      @(negedge clk);
      checks += 4;
      if (cordic_in_valid !== 1'b0) begin errors++; $display("FAIL midrst_in_valid got=%b exp=0", cordic_in_valid); end
      if (cordic_x !== '0) begin errors++; $display("FAIL midrst_x got=%h exp=0", cordic_x); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      if (res0_valid !== 1'b0) begin errors++; $display("FAIL midrst_res0 got=%b exp=0", res0_valid); end
      @(posedge clk); #1 rst = 0;
      for (int k = 0; k < 2 * LAT; k++) begin
         @(negedge clk);
         if (res0_valid || res1_valid || busy) viol++;
      end
      checks++;
      if (viol != 0) begin errors++; $display("FAIL midrst_ghost got=%0d exp=0", viol); end
   endtask

   task automatic test_push_pop();
      do_reset();
      res1_ready = 1;
      for (int k = 0; k <= LAT + 4; k++) begin
         @(posedge clk); #1;
         req0_valid = (k < 2);
         req0_x = (k == 0) ? 32'h6aaa : 32'h6bbb;
         req0_y = (k == 0) ? 32'h111 : 32'h222;
         res0_ready = (k == LAT + 2) || (k == LAT + 3);
         @(negedge clk);
         if (k < 2) begin
            checks++;
            if (req0_ready !== 1'b1) begin errors++; $display("FAIL pp_issue k=%0d got=%b exp=1", k, req0_ready); end
         end
         if (k == LAT + 3) begin
            checks += 2;
            if (res0_valid !== 1'b1) begin errors++; $display("FAIL pp_occ1 got=%b exp=1", res0_valid); end
            if (res0_mag !== 32'h6bbb) begin errors++; $display("FAIL pp_head got=%h exp=6bbb", res0_mag); end
         end
         if (k == LAT + 4) begin
            checks++;
            if (res0_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got=%b exp=0", res0_valid); end
         end
      end
      res0_ready = 1;
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_credit_stall();
      test_share();
      test_reset_mid();
      test_push_pop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
